// File: rtl/fft8_input_loader_if.sv
// fft8_input_loader_if: valid/ready sample stream carrying one complex Q8.8 sample per beat
interface fft8_input_loader_if #(parameter int DATA_W = 16);
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  modport master(output in_valid, in_re, in_im, in_last, input in_ready);
  modport slave(input in_valid, in_re, in_im, in_last, output in_ready);
endinterface

// File: rtl/fft8_input_loader.sv
// fft8_input_loader: double-buffered 8-sample frame collector that launches each frame into fft8
module fft8_input_loader #(parameter int DATA_W = 16) (
  input  logic              clk,
  input  logic              rst,
  fft8_input_loader_if.slave src,
  input  logic              fft_ready,
  output logic              fft_write,
  output logic              fft_start,
  output logic [DATA_W-1:0] x0r, x1r, x2r, x3r, x4r, x5r, x6r, x7r,
  output logic [DATA_W-1:0] x0i, x1i, x2i, x3i, x4i, x5i, x6i, x7i,
  output logic              busy,
  output logic              frame_err
);
  typedef enum logic [1:0] {IDLE, WRITE, START, WAIT} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic ready_d, load, full, rise, accept;
  logic [DATA_W-1:0] sh_re [8];
  logic [DATA_W-1:0] sh_im [8];
  logic [DATA_W-1:0] bk_re [8];
  logic [DATA_W-1:0] bk_im [8];
  assign full = cnt == 4'd8;
  assign src.in_ready = !full;
  assign accept = src.in_valid && !full;
  // only a fresh rising edge of fft_ready marks transform completion
  assign rise = fft_ready && !ready_d;
  always_comb begin
    state_nx = state;
    load = 1'b0;
    unique case (state)
      IDLE: begin
        load = full;
        state_nx = full ? WRITE : IDLE;
      end
      WRITE: state_nx = START;
      START: state_nx = WAIT;
      WAIT: begin
        load = rise && full;
        state_nx = !rise ? WAIT : (full ? WRITE : IDLE);
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ready_d <= 1'b0;
    end else begin
      state <= state_nx;
      ready_d <= fft_ready;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      frame_err <= 1'b0;
    end else if (load) begin
      cnt <= '0;
    end else if (accept) begin
      if (src.in_last && cnt < 4'd7) begin
        cnt <= '0;
        frame_err <= 1'b1;
      end else begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd7 && !src.in_last) frame_err <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_re[cnt[2:0]] <= src.in_re;
      sh_im[cnt[2:0]] <= src.in_im;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        bk_re[i] <= '0;
        bk_im[i] <= '0;
      end
    end else if (load) begin
      bk_re <= sh_re;
      bk_im <= sh_im;
    end
  end
  assign fft_write = state == WRITE || state == START;
  assign fft_start = state == START || state == WAIT;
  assign busy = state != IDLE;
  assign x0r = bk_re[0];
  assign x1r = bk_re[1];
  assign x2r = bk_re[2];
  assign x3r = bk_re[3];
  assign x4r = bk_re[4];
  assign x5r = bk_re[5];
  assign x6r = bk_re[6];
  assign x7r = bk_re[7];
  assign x0i = bk_im[0];
  assign x1i = bk_im[1];
  assign x2i = bk_im[2];
  assign x3i = bk_im[3];
  assign x4i = bk_im[4];
  assign x5i = bk_im[5];
  assign x6i = bk_im[6];
  assign x7i = bk_im[7];
endmodule

// File: tb/tb_fft8_input_loader.sv
// tb_fft8_input_loader: directed plus random stimulus against a frame-level reference model
module tb_fft8_input_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fft_ready = 1'b0;
  logic fft_write, fft_start, busy, frame_err;
  logic [15:0] xr [8];
  logic [15:0] xi [8];
  int checks = 0;
  int errors = 0;
  fft8_input_loader_if #(.DATA_W(16)) bus ();
  fft8_input_loader #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .src(bus), .fft_ready(fft_ready),
    .fft_write(fft_write), .fft_start(fft_start),
    .x0r(xr[0]), .x1r(xr[1]), .x2r(xr[2]), .x3r(xr[3]),
    .x4r(xr[4]), .x5r(xr[5]), .x6r(xr[6]), .x7r(xr[7]),
    .x0i(xi[0]), .x1i(xi[1]), .x2i(xi[2]), .x3i(xi[3]),
    .x4i(xi[4]), .x5i(xi[5]), .x6i(xi[6]), .x7i(xi[7]),
    .busy(busy), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [15:0] re; logic [15:0] im;} smp_t;
  smp_t m_sh[$];
  logic [15:0] m_re [8];
  logic [15:0] m_im [8];
  int m_age;
  logic m_rd, m_err;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic m_reset();
    m_sh.delete();
    m_age = -1;
    m_rd = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_re[i] = '0;
      m_im[i] = '0;
    end
  endtask
  // m_age: -1 idle, otherwise cycles since the frame was handed over (saturating at 2 while waiting)
  always @(posedge clk) begin
    bit rise, exitw, ld, acc;
    if (rst) begin
      rise = fft_ready && !m_rd;
      exitw = m_age >= 2 && rise;
      ld = m_sh.size() == 8 && (m_age < 0 || exitw);
      acc = bus.in_valid && m_sh.size() != 8;
      if (ld) begin
        for (int i = 0; i < 8; i++) begin
          m_re[i] = m_sh[i].re;
          m_im[i] = m_sh[i].im;
        end
        m_sh.delete();
        m_age = 0;
      end else if (exitw) m_age = -1;
      else if (m_age >= 0 && m_age < 2) m_age++;
      if (acc) begin
        if (bus.in_last && m_sh.size() < 7) begin
          m_sh.delete();
          m_err = 1'b1;
        end else begin
          m_sh.push_back({bus.in_re, bus.in_im});
          if (m_sh.size() == 8 && !bus.in_last) m_err = 1'b1;
        end
      end
      m_rd = fft_ready;
    end
  end
  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, m_sh.size() != 8);
    chk("fft_write", fft_write, m_age == 0 || m_age == 1);
    chk("fft_start", fft_start, m_age >= 1);
    chk("busy", busy, m_age >= 0);
    chk("frame_err", frame_err, m_err);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("x%0dr", i), xr[i], m_re[i]);
      chk($sformatf("x%0di", i), xi[i], m_im[i]);
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    logic r;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_re = re;
    bus.in_im = im;
    bus.in_last = last;
    do begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!r && n < 50);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected accept within 50 cycles");
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    m_reset();
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_x0r", xr[0], 0);
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask
  task automatic finish_frame();
    fft_ready = 1'b0;
    tick(4);
    fft_ready = 1'b1;
    tick(1);
    fft_ready = 1'b0;
    tick(1);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    m_reset();
    tick(3);
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) send(16'h1111 * i[15:0], 16'h0042, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) send(16'(i * 256), 16'h0000, i == 7);
    tick(5);
    chk("ramp_x0r", xr[0], 16'h0000);
    chk("ramp_x3r", xr[3], 16'h0300);
    chk("ramp_x7r", xr[7], 16'h0700);
    chk("ramp_x7i", xi[7], 16'h0000);
    chk("ramp_wait_start", fft_start, 1);
    chk("model_x5r", m_re[5], 16'h0500);
    fft_ready = 1'b1;
    tick(1);
    fft_ready = 1'b0;
    chk("ramp_done_start", fft_start, 0);
    tick(1);
    for (int i = 0; i < 16; i++) send(16'(i * 256), 16'(i), i % 8 == 7);
    tick(4);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_hold_x0r", xr[0], 16'h0000);
    chk("bp_hold_x7r", xr[7], 16'h0700);
    fft_ready = 1'b1;
    tick(1);
    chk("bp_f2_x0r", xr[0], 16'h0800);
    chk("bp_f2_x7r", xr[7], 16'h0f00);
    chk("bp_write", fft_write, 1);
    chk("bp_ready_again", bus.in_ready, 1);
    finish_frame();
    for (int i = 0; i < 5; i++) send(16'h0a00 + 16'(i), 16'hff00, i == 4);
    tick(1);
    chk("early_err", frame_err, 1);
    chk("early_no_load", busy, 0);
    for (int i = 0; i < 8; i++) send(16'h0b00 + 16'(i), 16'(-i), i == 7);
    tick(4);
    chk("early_next_x0r", xr[0], 16'h0b00);
    chk("early_next_x7i", xi[7], 16'hfff9);
    finish_frame();
    do_reset();
    chk("err_cleared", frame_err, 0);
    for (int i = 0; i < 8; i++) send(16'h0c00 + 16'(i), 16'h0001, 1'b0);
    tick(1);
    chk("miss_err", frame_err, 1);
    tick(2);
    chk("miss_launched", busy, 1);
    finish_frame();
    fft_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'h0d00 + 16'(i), 16'h0002, i == 7);
    tick(8);
    chk("held_busy", busy, 1);
    chk("held_start", fft_start, 1);
    fft_ready = 1'b0;
    tick(1);
    fft_ready = 1'b1;
    tick(1);
    chk("rise_busy", busy, 0);
    chk("rise_start", fft_start, 0);
    fft_ready = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bus.in_valid = $urandom % 3 != 0;
      bus.in_re = 16'($urandom);
      bus.in_im = 16'($urandom);
      bus.in_last = (m_sh.size() == 7) ^ ($urandom % 12 == 0);
      fft_ready = $urandom % 4 == 0;
      if (k == 200) begin
        rst = 1'b0;
        m_reset();
        tick(1);
        rst = 1'b1;
      end
      tick(1);
    end
    bus.in_valid = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft8_input_loader.md
Name: fft8_input_loader

Overview:
Upstream feeder for the fft8 core. Accepts a serial stream of complex Q8.8 samples over a valid/ready handshake and collects 8 of them into a shadow buffer. It then presents each completed frame as a coherent parallel vector on x0r..x7i, sequences fft8's write and start inputs, and waits for fft8 ready. Double buffering lets the next frame fill while the current transform runs.

Parameters:
DATA_W, 16, sample word width (signed Q8.8, two's complement); frame length is fixed at 8.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
in_valid  in  1  input sample valid
in_ready  out  1  loader can accept a sample
in_re  in  DATA_W  sample real part
in_im  in  DATA_W  sample imaginary part
in_last  in  1  marks the 8th sample of a frame (checked only)
fft_ready  in  1  fft8 ready output
fft_write  out  1  to fft8 write
fft_start  out  1  to fft8 start
x0r..x7r  out  DATA_W each  parallel real outputs to fft8, index = arrival order
x0i..x7i  out  DATA_W each  parallel imaginary outputs to fft8
busy  out  1  state != IDLE
frame_err  out  1  sticky framing error

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-low. While rst=0:
  - state=IDLE; shadow count cnt=0; ready_d=0.
  - All x*, fft_write, fft_start, busy and frame_err are 0.
  - in_ready=1, which is combinational: in_ready = (cnt != 8).
- Shadow buffer: 8 entries of {re, im} plus a 4-bit counter cnt (0..8).
  - A handshake (in_valid & in_ready) writes entry[cnt] and increments cnt.
  - cnt==8 means the shadow buffer is full; in_ready=0.
- Framing checks:
  - in_last accepted with cnt<7: the partial frame is discarded, cnt<=0, frame_err<=1.
  - 8th sample accepted without in_last: frame_err<=1, and the frame proceeds normally.
  - frame_err clears only on reset.
- FSM states: IDLE, WRITE, START, WAIT.
  - IDLE: if cnt==8, load all 8 shadow entries into the x* bank in one edge, cnt<=0, go to WRITE. Otherwise stay in IDLE.
  - WRITE: fft_write=1, fft_start=0. Lasts 1 cycle, then START.
  - START: fft_write=1, fft_start=1. Lasts 1 cycle, then WAIT.
  - WAIT: fft_write=0, fft_start=1.
    - Exit only on a fresh rising edge of fft_ready (fft_ready & ~ready_d, where ready_d is fft_ready registered every cycle).
    - On exit with cnt==8: load the bank, cnt<=0, go straight to WRITE.
    - On exit with cnt<8: go to IDLE, where fft_start=0.
- Outputs fft_write, fft_start and busy are registered (decoded from the state register).
- x* bank changes only on load edges. It is stable throughout WRITE, START and WAIT.
- Latency: if the 8th sample is accepted at edge E while in IDLE:
  - bank loaded and state=WRITE at E+1;
  - START at E+2;
  - WAIT at E+3.
- Sample acceptance continues in every state while cnt<8, so the next frame fills during WAIT.
- On a load edge cnt is 8, so in_ready=0 and no accept can coincide with the load.
- fft_ready already high on entry to WAIT does not count as completion; it must fall and rise again.
- Reset asserted mid-frame or mid-WAIT: immediate return to the reset values above; partial shadow contents are discarded.
- No arithmetic is performed: data passes through bit-exact, with no saturation or scaling.

Test Plan:
1. Reset: drive a partial frame of 3 samples, then pulse rst=0 -> all outputs 0, in_ready=1, busy=0. A following full frame loads as entries 0..7, not 3..10.
2. Ramp frame: in_re=0x0000,0x0100,...,0x0700, in_im=0, in_last on the 8th sample -> x0r..x7r=0x0000..0x0700, x*i=0. fft_write high for 2 cycles starting at E+1; fft_start high from E+2 until the cycle after the fft_ready rising edge.
3. Backpressure: stream 16 samples back-to-back with fft_ready held 0 -> in_ready drops after the 16th accept and x* still holds frame 1. Raise fft_ready -> frame 2 (0x0800..0x0F00) loads, WRITE re-enters, in_ready=1 on the next cycle.
4. Early in_last on the 5th sample -> frame_err=1, no load. The next 8 samples (with in_last on the 8th) load correctly.
5. Missing in_last on the 8th sample -> frame_err=1, frame still loaded and launched.
6. fft_ready held 1 across entry to WAIT -> no exit. Drop it for 1 cycle and raise it again -> exit to IDLE on the rising edge, then fft_start=0.
